// File: rtl/key_event_gen.sv
// Key conditioner: per-key synchroniser and debounce/long-press FSM on a shared 1 ms tick.
// Optional auto-repeat of key_press after a long press is enabled by defining KEY_REPEAT_EN.
module key_event_gen #(
  parameter int KEY_NUM     = 4,
  parameter int TICK_CYCLES = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int MS_MAX0 = (LONG_MS > DEBOUNCE_MS) ? LONG_MS : DEBOUNCE_MS;
  localparam int MS_MAX  = (MS_MAX0 > REPEAT_MS) ? MS_MAX0 : REPEAT_MS;
  localparam int CW      = $clog2(MS_MAX + 1);
  localparam int PW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_MS - 1);
`endif

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  logic [PW-1:0]      presc_q, presc_d;
  logic               tick;
  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] pressed_s;

  // Free-running prescaler shared by all keys; key activity never restarts it.
  assign tick    = (presc_q == TICK_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      presc_q <= presc_d;
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_q, long_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          longp_q, longp_d;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      long_d    = long_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      longp_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pressed_s[g]) begin
            state_d = ST_PRESS_DB;
            cnt_d   = '0;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed_s[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            long_d  = 1'b0;
          end else if (tick) begin
            if (cnt_q == DB_LAST) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_HELD: begin
          if (!pressed_s[g]) begin
            state_d = ST_RELEASE_DB;
            cnt_d   = '0;
          end else if (tick) begin
            if (!long_q && cnt_q == LONG_LAST) begin
              longp_d = 1'b1;
              long_d  = 1'b1;
              cnt_d   = '0;
            end
`ifdef KEY_REPEAT_EN
            else if (long_q && cnt_q == REP_LAST) begin
              press_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
`else
            // Once key_long has fired there is nothing left to time while held.
            else if (!long_q) begin
              cnt_d = cnt_q + CW'(1);
            end
`endif
          end
        end
        default: begin
          // Bounce back to HELD keeps long_q so key_long cannot fire twice.
          if (pressed_s[g]) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == DB_LAST) begin
              state_d   = ST_IDLE;
              cnt_d     = '0;
              long_d    = 1'b0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        long_q    <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        longp_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        long_q    <= long_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        longp_q   <= longp_d;
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = longp_q;
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: directed scenarios plus random key activity, all outputs
// compared every cycle against a tick-counting reference model.
module tb_key_event_gen;

  localparam int KN = 4;
  localparam int TC = 10;
  localparam int DB = 3;
  localparam int LM = 8;
  localparam int RM = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [KN-1:0] key     = '1;
  logic [KN-1:0] key_level, key_press, key_release, key_long;

  always #5 sys_clk = ~sys_clk;

  key_event_gen #(
    .KEY_NUM    (KN),
    .TICK_CYCLES(TC),
    .DEBOUNCE_MS(DB),
    .LONG_MS    (LM),
    .REPEAT_MS  (RM)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: synchroniser delay line, tick phase and per-key tick tallies.
  logic [KN-1:0]   m_s1, m_s2, m_prev, m_level, m_long_done;
  int              m_presc;
  int              m_db[KN];
  int              m_hold[KN];
  logic [4*KN-1:0] exp_q[$];

  int dut_press_n[KN] = '{default: 0};
  int dut_rel_n[KN]   = '{default: 0};
  int dut_long_n[KN]  = '{default: 0};
  int mdl_press_n[KN] = '{default: 0};

  task automatic model_reset();
    m_s1        = '1;
    m_s2        = '1;
    m_prev      = '0;
    m_level     = '0;
    m_long_done = '0;
    m_presc     = 0;
    for (int i = 0; i < KN; i++) begin
      m_db[i]   = 0;
      m_hold[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [KN-1:0] pressed, np, nr, nl;
    bit            tick;
    pressed = ~m_s2;
    tick    = (m_presc == TC - 1);
    np = '0; nr = '0; nl = '0;
    for (int i = 0; i < KN; i++) begin
      if (pressed[i] != m_level[i]) begin
        // A tick counts toward debounce only once the new level has been seen for a cycle.
        m_hold[i] = 0;
        if (pressed[i] == m_prev[i] && tick) begin
          if (m_db[i] + 1 == DB) begin
            m_db[i]    = 0;
            m_level[i] = pressed[i];
            if (pressed[i]) np[i] = 1'b1;
            else begin
              nr[i]          = 1'b1;
              m_long_done[i] = 1'b0;
            end
          end else m_db[i]++;
        end
      end else begin
        m_db[i] = 0;
        if (m_level[i] && m_prev[i] && tick) begin
          m_hold[i]++;
          if (!m_long_done[i]) begin
            if (m_hold[i] == LM) begin
              nl[i]          = 1'b1;
              m_long_done[i] = 1'b1;
              m_hold[i]      = 0;
            end
          end else if (REP_EN && m_hold[i] == RM) begin
            np[i]     = 1'b1;
            m_hold[i] = 0;
          end
        end
      end
    end
    exp_q.push_back({m_level, np, nr, nl});
    m_presc = tick ? 0 : m_presc + 1;
    m_s2    = m_s1;
    m_s1    = key;
    m_prev  = pressed;
  endtask

  // Key must already be driven; one clock, then compare at the falling edge.
  task automatic cycle();
    logic [4*KN-1:0] e;
    model_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    e = exp_q.pop_front();
    chk("level",   32'(key_level),   32'(e[4*KN-1:3*KN]));
    chk("press",   32'(key_press),   32'(e[3*KN-1:2*KN]));
    chk("release", 32'(key_release), 32'(e[2*KN-1:KN]));
    chk("long",    32'(key_long),    32'(e[KN-1:0]));
    for (int i = 0; i < KN; i++) begin
      dut_press_n[i] += int'(key_press[i]);
      dut_rel_n[i]   += int'(key_release[i]);
      dut_long_n[i]  += int'(key_long[i]);
      mdl_press_n[i] += int'(e[2*KN+i]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   32'(key_level),   32'd0);
    chk({tag, "_press"},   32'(key_press),   32'd0);
    chk({tag, "_release"}, 32'(key_release), 32'd0);
    chk({tag, "_long"},    32'(key_long),    32'd0);
  endtask

  initial begin
    int lat, c0, c3, p_cyc, l_cyc, pa, ra, la, ma;
    bit got;

    model_reset();
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    run(20);

    // Clean press on key 0.
    key[0] = 1'b0;
    got = 0; lat = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (!got && key_press[0]) begin
        got = 1;
        lat = i + 1;
        chk("clean_level", 32'(key_level[0]), 32'd1);
      end
    end
    chk("clean_seen", 32'(got), 32'd1);
    chk("clean_latency_window", 32'(lat >= 22 && lat <= 33), 32'd1);
    chk("clean_other_presses", 32'(dut_press_n[1] + dut_press_n[2] + dut_press_n[3]), 32'd0);
    key[0] = 1'b1;
    run(50);

    // Bounce on key 1: never stable long enough.
    pa = dut_press_n[1]; ra = dut_rel_n[1];
    for (int t = 0; t < 200; t++) begin
      if (t % 15 == 0) key[1] = ~key[1];
      cycle();
    end
    key[1] = 1'b1;
    run(40);
    chk("bounce_press",   32'(dut_press_n[1] - pa), 32'd0);
    chk("bounce_release", 32'(dut_rel_n[1] - ra), 32'd0);
    chk("bounce_level",   32'(key_level[1]), 32'd0);

    // Long press on key 2 with a short release glitch after key_long.
    pa = dut_press_n[2]; ra = dut_rel_n[2]; la = dut_long_n[2]; ma = mdl_press_n[2];
    p_cyc = -1; l_cyc = -1;
    key[2] = 1'b0;
    for (int t = 0; t < 150; t++) begin
      if (t == 120) key[2] = 1'b1;
      if (t == 125) key[2] = 1'b0;
      cycle();
      if (p_cyc < 0 && key_press[2]) p_cyc = cyc;
      if (l_cyc < 0 && key_long[2]) l_cyc = cyc;
    end
    chk("long_gap", 32'(l_cyc - p_cyc), 32'd80);
    chk("glitch_no_release", 32'(dut_rel_n[2] - ra), 32'd0);
    key[2] = 1'b1;
    got = 0; lat = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (!got && key_release[2]) begin
        got = 1;
        lat = i + 1;
      end
    end
    chk("long_release_window", 32'(got && lat >= 22 && lat <= 33), 32'd1);
    chk("long_count",    32'(dut_long_n[2] - la), 32'd1);
    chk("long_releases", 32'(dut_rel_n[2] - ra), 32'd1);
    chk("long_presses",  32'(dut_press_n[2] - pa), 32'(mdl_press_n[2] - ma));

    // Simultaneous press on keys 0 and 3.
    c0 = -1; c3 = -1;
    key[0] = 1'b0; key[3] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (c0 < 0 && key_press[0]) c0 = cyc;
      if (c3 < 0 && key_press[3]) c3 = cyc;
    end
    chk("simul_seen", 32'(c0 > 0), 32'd1);
    chk("simul_same_cycle", 32'(c3), 32'(c0));
    key[0] = 1'b1; key[3] = 1'b1;
    run(50);

    // Reset while key 1 is held and accepted.
    key[1] = 1'b0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      cycle();
      if (key_level[1]) got = 1;
    end
    chk("rst_hold_accepted", 32'(got), 32'd1);
    run(5);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    model_reset();
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    got = 0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!got && key_press[1]) begin
        got = 1;
        lat = i + 1;
      end
    end
    chk("rst_repress", 32'(got && lat <= 32), 32'd1);
    key[1] = 1'b1;
    run(50);

    // Long hold on key 0: single press, or repeats when auto-repeat is built in.
    pa = dut_press_n[0]; la = dut_long_n[0];
    key[0] = 1'b0;
    run(200);
    key[0] = 1'b1;
    run(50);
    chk("hold_long_once", 32'(dut_long_n[0] - la), 32'd1);
    chk("hold_press_count", 32'(dut_press_n[0] - pa), REP_EN ? 32'd3 : 32'd1);

    // Random key activity on all keys.
    for (int ep = 0; ep < 40; ep++) begin
      key = KN'($urandom_range(0, (1 << KN) - 1));
      run($urandom_range(1, 70));
    end
    key = '1;
    run(60);
    for (int i = 0; i < KN; i++) begin
      chk($sformatf("press_total_%0d", i), 32'(dut_press_n[i]), 32'(mdl_press_n[i]));
      chk($sformatf("release_le_press_%0d", i), 32'(dut_rel_n[i] <= dut_press_n[i]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
